// File: rtl/bram_pkg.sv
// Shared definitions for the block-RAM family: address-width helper and the
// mode strings accepted by the RAM_PERFORMANCE and WRITE_MODE parameters.
package bram_pkg;

  localparam string MODE_HIGH_PERFORMANCE = "HIGH_PERFORMANCE";
  localparam string MODE_LOW_LATENCY      = "LOW_LATENCY";
  localparam string MODE_READ_FIRST       = "READ_FIRST";
  localparam string MODE_WRITE_FIRST      = "WRITE_FIRST";

  // Number of bits needed to represent value; 0 for value 0.
  function automatic int clogb2(input int value);
    int v;
    int res;
    v   = value;
    res = 0;
    while (v > 0) begin
      res = res + 1;
      v   = v >> 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/bram_out_stage.sv
// Optional output register of the read pipeline: captures data and valid when
// ce is high, holds otherwise, cleared by the synchronous reset.
module bram_out_stage #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid
);

  logic [WIDTH-1:0] data_d;
  logic [WIDTH-1:0] data_q;
  logic             valid_d;
  logic             valid_q;

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (ce) begin
      data_d  = in_data;
      valid_d = in_valid;
    end else begin
      data_d  = data_q;
      valid_d = valid_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign out_data  = data_q;
  assign out_valid = valid_q;

endmodule

// File: rtl/sdp_bytewrite_bram.sv
// Simple dual-port RAM with byte-lane writes on port A, a registered read on
// port B, selectable collision policy and optional output register.
module sdp_bytewrite_bram
  import bram_pkg::*;
#(
  parameter int    RAM_WIDTH       = 32,
  parameter int    BYTE_WIDTH      = 8,
  parameter int    RAM_DEPTH       = 1024,
  parameter string RAM_PERFORMANCE = "HIGH_PERFORMANCE",
  parameter string WRITE_MODE      = "READ_FIRST",
  parameter string INIT_FILE       = "",
  localparam int   NB_COL          = RAM_WIDTH / BYTE_WIDTH,
  localparam int   AW              = (clogb2(RAM_DEPTH - 1) > 1) ? clogb2(RAM_DEPTH - 1) : 1
) (
  input  logic                 clka,
  input  logic                 rsta,
  input  logic [AW-1:0]        addra,
  input  logic [RAM_WIDTH-1:0] dina,
  input  logic [NB_COL-1:0]    wea,
  input  logic                 ena,
  input  logic [AW-1:0]        addrb,
  input  logic                 enb,
  input  logic                 regceb,
  output logic [RAM_WIDTH-1:0] doutb,
  output logic                 doutb_valid
);

  localparam bit          WRITE_FIRST_L = (WRITE_MODE == MODE_WRITE_FIRST);
  localparam logic [AW:0] DEPTH_L       = (AW + 1)'(RAM_DEPTH);

  if (RAM_WIDTH % BYTE_WIDTH != 0) begin : g_bad_width
    $error("sdp_bytewrite_bram: RAM_WIDTH must be a multiple of BYTE_WIDTH");
  end
  if (RAM_PERFORMANCE != MODE_HIGH_PERFORMANCE && RAM_PERFORMANCE != MODE_LOW_LATENCY) begin : g_bad_perf
    $error("sdp_bytewrite_bram: illegal RAM_PERFORMANCE");
  end
  if (WRITE_MODE != MODE_READ_FIRST && WRITE_MODE != MODE_WRITE_FIRST) begin : g_bad_wmode
    $error("sdp_bytewrite_bram: illegal WRITE_MODE");
  end

  logic [RAM_WIDTH-1:0] mem [RAM_DEPTH];

  // Power-up contents are all zero.
  initial begin
    for (int i = 0; i < RAM_DEPTH; i++) begin
      mem[i] = '0;
    end
  end

  logic                 wr_in_range;
  logic                 rd_in_range;
  logic                 collision;
  logic [RAM_WIDTH-1:0] rd_word;
  logic [RAM_WIDTH-1:0] s1_data_d;
  logic [RAM_WIDTH-1:0] s1_data_q;
  logic                 s1_valid_d;
  logic                 s1_valid_q;

  // Out-of-range addresses neither write nor alias, so they can never collide.
  assign wr_in_range = {1'b0, addra} < DEPTH_L;
  assign rd_in_range = {1'b0, addrb} < DEPTH_L;
  assign collision   = ena && enb && wr_in_range && (addra == addrb) && (|wea);

  always_ff @(posedge clka) begin
    if (ena && wr_in_range) begin
      for (int i = 0; i < NB_COL; i++) begin
        if (wea[i]) begin
          mem[addra][i*BYTE_WIDTH +: BYTE_WIDTH] <= dina[i*BYTE_WIDTH +: BYTE_WIDTH];
        end
      end
    end
  end

  always_comb begin
    rd_word = '0;
    if (rd_in_range) begin
      rd_word = mem[addrb];
    end else begin
      rd_word = '0;
    end
    for (int i = 0; i < NB_COL; i++) begin
      if (WRITE_FIRST_L && collision && wea[i]) begin
        rd_word[i*BYTE_WIDTH +: BYTE_WIDTH] = dina[i*BYTE_WIDTH +: BYTE_WIDTH];
      end
    end
  end

  always_comb begin
    s1_data_d  = s1_data_q;
    s1_valid_d = 1'b0;
    if (enb) begin
      s1_data_d  = rd_word;
      s1_valid_d = 1'b1;
    end else begin
      s1_data_d  = s1_data_q;
      s1_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clka) begin
    if (rsta) begin
      s1_data_q  <= '0;
      s1_valid_q <= 1'b0;
    end else begin
      s1_data_q  <= s1_data_d;
      s1_valid_q <= s1_valid_d;
    end
  end

  if (RAM_PERFORMANCE == MODE_HIGH_PERFORMANCE) begin : g_out_reg
    bram_out_stage #(
      .WIDTH(RAM_WIDTH)
    ) u_out_stage (
      .clk      (clka),
      .rst      (rsta),
      .ce       (regceb),
      .in_data  (s1_data_q),
      .in_valid (s1_valid_q),
      .out_data (doutb),
      .out_valid(doutb_valid)
    );
  end else begin : g_out_direct
    logic unused_regceb;
    assign unused_regceb = regceb;
    assign doutb         = s1_data_q;
    assign doutb_valid   = s1_valid_q;
  end

endmodule

// File: tb/tb_sdp_bytewrite_bram.sv
// Scoreboard bench: a HIGH_PERFORMANCE/READ_FIRST and a LOW_LATENCY/WRITE_FIRST
// instance share stimulus; a reference model predicts each cycle's output.
module tb_sdp_bytewrite_bram;

  localparam int DEPTH = 12;
  localparam int AW    = 4;

  typedef struct packed {
    logic [31:0] data;
    logic        valid;
  } exp_t;

  logic          clk = 1'b0;
  logic          rsta = 1'b1;
  logic [AW-1:0] addra = '0;
  logic [31:0]   dina = '0;
  logic [3:0]    wea = '0;
  logic          ena = 1'b0;
  logic [AW-1:0] addrb = '0;
  logic          enb = 1'b0;
  logic          regceb = 1'b0;
  logic [31:0]   doutb_hp;
  logic          valid_hp;
  logic [31:0]   doutb_ll;
  logic          valid_ll;

  int checks = 0;
  int errors = 0;

  exp_t q_hp[$];
  exp_t q_ll[$];

  // Reference state: memory plus what each read port should currently show.
  logic [31:0] ref_mem [DEPTH];
  logic [31:0] hp_s1_data = '0;
  logic        hp_s1_valid = 1'b0;
  logic [31:0] hp_out_data = '0;
  logic        hp_out_valid = 1'b0;
  logic [31:0] ll_data = '0;
  logic        ll_valid = 1'b0;

  always #5 clk = ~clk;

  sdp_bytewrite_bram #(
    .RAM_WIDTH(32), .BYTE_WIDTH(8), .RAM_DEPTH(DEPTH),
    .RAM_PERFORMANCE("HIGH_PERFORMANCE"), .WRITE_MODE("READ_FIRST"), .INIT_FILE("")
  ) dut_hp (
    .clka(clk), .rsta(rsta), .addra(addra), .dina(dina), .wea(wea), .ena(ena),
    .addrb(addrb), .enb(enb), .regceb(regceb), .doutb(doutb_hp), .doutb_valid(valid_hp)
  );

  sdp_bytewrite_bram #(
    .RAM_WIDTH(32), .BYTE_WIDTH(8), .RAM_DEPTH(DEPTH),
    .RAM_PERFORMANCE("LOW_LATENCY"), .WRITE_MODE("WRITE_FIRST"), .INIT_FILE("")
  ) dut_ll (
    .clka(clk), .rsta(rsta), .addra(addra), .dina(dina), .wea(wea), .ena(ena),
    .addrb(addrb), .enb(enb), .regceb(regceb), .doutb(doutb_ll), .doutb_valid(valid_ll)
  );

  // Drive one cycle of stimulus and push the outputs expected after its edge.
  task automatic step(input logic i_ena, input logic [3:0] i_wea, input logic [AW-1:0] i_addra,
                      input logic [31:0] i_dina, input logic i_enb, input logic [AW-1:0] i_addrb,
                      input logic i_regceb, input logic i_rsta);
    logic [31:0] old_word;
    logic [31:0] wf_word;
    @(negedge clk);
    #1;
    ena = i_ena; wea = i_wea; addra = i_addra; dina = i_dina;
    enb = i_enb; addrb = i_addrb; regceb = i_regceb; rsta = i_rsta;

    old_word = (int'(i_addrb) < DEPTH) ? ref_mem[i_addrb] : 32'h0;
    wf_word  = old_word;
    if (i_ena && i_enb && i_addra == i_addrb && int'(i_addra) < DEPTH) begin
      for (int b = 0; b < 4; b++) begin
        if (i_wea[b]) wf_word[b*8 +: 8] = i_dina[b*8 +: 8];
      end
    end

    if (i_rsta) begin
      hp_s1_data = 32'h0; hp_s1_valid = 1'b0;
      hp_out_data = 32'h0; hp_out_valid = 1'b0;
      ll_data = 32'h0; ll_valid = 1'b0;
    end else begin
      if (i_regceb) begin
        hp_out_data  = hp_s1_data;
        hp_out_valid = hp_s1_valid;
      end
      if (i_enb) begin
        hp_s1_data = old_word; hp_s1_valid = 1'b1;
        ll_data    = wf_word;  ll_valid    = 1'b1;
      end else begin
        hp_s1_valid = 1'b0;
        ll_valid    = 1'b0;
      end
    end

    if (i_ena && int'(i_addra) < DEPTH) begin
      for (int b = 0; b < 4; b++) begin
        if (i_wea[b]) ref_mem[i_addra][b*8 +: 8] = i_dina[b*8 +: 8];
      end
    end

    q_hp.push_back('{data: hp_out_data, valid: hp_out_valid});
    q_ll.push_back('{data: ll_data, valid: ll_valid});
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] we);
    step(1'b1, we, a, d, 1'b0, '0, 1'b1, 1'b0);
  endtask

  task automatic rd(input logic [AW-1:0] a);
    step(1'b0, 4'h0, '0, 32'h0, 1'b1, a, 1'b1, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 4'h0, '0, 32'h0, 1'b0, '0, 1'b1, 1'b0);
  endtask

  // Monitor: every cycle both ports present an output; compare against the queue.
  always @(negedge clk) begin
    exp_t e;
    if (q_hp.size() != 0) begin
      e = q_hp.pop_front();
      checks++;
      if (doutb_hp !== e.data || valid_hp !== e.valid) begin
        errors++;
        $display("FAIL hp_out got data=%h valid=%b expected data=%h valid=%b t=%0t",
                 doutb_hp, valid_hp, e.data, e.valid, $time);
      end
    end
    if (q_ll.size() != 0) begin
      e = q_ll.pop_front();
      checks++;
      if (doutb_ll !== e.data || valid_ll !== e.valid) begin
        errors++;
        $display("FAIL ll_out got data=%h valid=%b expected data=%h valid=%b t=%0t",
                 doutb_ll, valid_ll, e.data, e.valid, $time);
      end
    end
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'h0;

    // Reset, idle, then a single read of zero-initialised address 3.
    step(1'b0, 4'h0, '0, 32'h0, 1'b0, '0, 1'b1, 1'b1);
    step(1'b0, 4'h0, '0, 32'h0, 1'b0, '0, 1'b1, 1'b1);
    idle(5);
    rd(4'd3);
    idle(3);

    // Byte-lane write: expect 0xAA22CC44 at address 5.
    wr(4'd5, 32'hAABBCCDD, 4'b1111);
    wr(4'd5, 32'h11223344, 4'b0101);
    rd(4'd5);
    idle(3);

    // Collision at address 7, then a follow-up read.
    step(1'b1, 4'b0011, 4'd7, 32'hDEADBEEF, 1'b1, 4'd7, 1'b1, 1'b0);
    rd(4'd7);
    idle(3);

    // Out-of-range write and read.
    wr(4'd13, 32'hFFFFFFFF, 4'b1111);
    for (int a = 0; a < 14; a++) rd(AW'(a));
    idle(3);

    // Output-register stall drops address 2.
    wr(4'd1, 32'h01010101, 4'b1111);
    wr(4'd2, 32'h02020202, 4'b1111);
    wr(4'd3, 32'h03030303, 4'b1111);
    rd(4'd1);
    rd(4'd2);
    step(1'b0, 4'h0, '0, 32'h0, 1'b1, 4'd3, 1'b0, 1'b0);
    idle(3);

    // Reset pulse mid-stream with a write to address 9 in the same cycle.
    rd(4'd0); rd(4'd1); rd(4'd2);
    step(1'b1, 4'b1111, 4'd9, 32'h99887766, 1'b1, 4'd3, 1'b1, 1'b1);
    rd(4'd5); rd(4'd9);
    idle(3);

    // Randomised traffic including out-of-range addresses and resets.
    for (int i = 0; i < 1500; i++) begin
      step($urandom_range(0, 1) == 1, 4'($urandom), AW'($urandom_range(0, 15)), $urandom,
           $urandom_range(0, 9) < 7, AW'($urandom_range(0, 15)),
           $urandom_range(0, 9) < 8, $urandom_range(0, 99) < 3);
    end
    idle(2);

    for (int i = 0; i < 20 && (q_hp.size() != 0 || q_ll.size() != 0); i++) begin
      @(negedge clk);
      #1;
    end
    if (q_hp.size() != 0 || q_ll.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain got pending=%0d expected pending=0", q_hp.size() + q_ll.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
